// File: rtl/multi_clk_divider.sv
// Multi-channel programmable clock divider: per-channel counter with shadowed
// divisor/mode, toggle (50% duty) or pulse output, and a global phase-align strobe.
module multi_clk_divider #(
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sync,
    input  logic [CHANNELS-1:0]           en,
    input  logic [CHANNELS-1:0]           mode,
    input  logic [CHANNELS*CNT_WIDTH-1:0] div,
    output logic [CHANNELS-1:0]           clk_out,
    output logic [CHANNELS-1:0]           tick
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
            logic [CNT_WIDTH-1:0] n_q, n_d;
            logic                 m_q, m_d;
            logic                 out_q, out_d;
            logic                 tick_q, tick_d;
            logic [CNT_WIDTH-1:0] div_c;
            logic [CNT_WIDTH-1:0] div_eff;
            logic                 wrap;
            logic                 load;

            assign div_c   = div[gi*CNT_WIDTH +: CNT_WIDTH];
            assign div_eff = (div_c == '0) ? ONE : div_c;

            // ">=" rather than "==" keeps cnt bounded should a smaller N ever be
            // latched while cnt is already past it.
            assign wrap = en[gi] && (cnt_q >= (n_q - ONE));
            assign load = sync || !en[gi] || wrap;

            always_comb begin
                cnt_d  = cnt_q + ONE;
                out_d  = m_q ? 1'b0 : out_q;
                tick_d = 1'b0;
                n_d    = load ? div_eff : n_q;
                m_d    = load ? mode[gi] : m_q;
                if (sync || !en[gi]) begin
                    cnt_d = '0;
                    out_d = 1'b0;
                end else if (wrap) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    out_d  = m_q ? 1'b1 : ~out_q;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_q  <= '0;
                    n_q    <= ONE;
                    m_q    <= 1'b0;
                    out_q  <= 1'b0;
                    tick_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    n_q    <= n_d;
                    m_q    <= m_d;
                    out_q  <= out_d;
                    tick_q <= tick_d;
                end
            end

            assign clk_out[gi] = out_q;
            assign tick[gi]    = tick_q;
        end
    endgenerate

endmodule

// File: tb/tb_multi_clk_divider.sv
// Directed self-checking bench for multi_clk_divider: default 4x16 instance plus
// a 1-channel, 2-bit instance for the narrow-counter case.
module tb_multi_clk_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        sync;
    logic [3:0]  en;
    logic [3:0]  mode;
    logic [63:0] div;
    logic [3:0]  clk_out;
    logic [3:0]  tick;

    logic [0:0]  s_en;
    logic [0:0]  s_mode;
    logic [1:0]  s_div;
    logic [0:0]  s_clk_out;
    logic [0:0]  s_tick;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    always #5 clk = ~clk;

    multi_clk_divider #(.CHANNELS(4), .CNT_WIDTH(16)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .sync    (sync),
        .en      (en),
        .mode    (mode),
        .div     (div),
        .clk_out (clk_out),
        .tick    (tick)
    );

    multi_clk_divider #(.CHANNELS(1), .CNT_WIDTH(2)) u_small (
        .clk     (clk),
        .reset   (reset),
        .sync    (sync),
        .en      (s_en),
        .mode    (s_mode),
        .div     (s_div),
        .clk_out (s_clk_out),
        .tick    (s_tick)
    );

    task automatic check(input string tag, input int obs, input int exp_v);
        total_cnt++;
        assert (obs === exp_v) begin
            pass_cnt++;
            $display("check %s observed=%0d expected=%0d ok", tag, obs, exp_v);
        end else begin
            fail_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset  = 1'b0;
        sync   = 1'b0;
        en     = '0;
        mode   = '0;
        div    = '0;
        s_en   = '0;
        s_mode = 1'b1;
        s_div  = 2'd3;
        step(2);
        check("reset_clk_out", clk_out, 0);
        check("reset_tick", tick, 0);
        check("reset_small_tick", s_tick, 0);
        reset = 1'b1;
        step(1);

        // ch0 toggle, N=5: tick every 5, clk_out period 10 (5 high, 5 low)
        div[0 +: 16] = 16'd5;
        mode[0]      = 1'b0;
        step(1);
        en[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            check($sformatf("tog_tick0_k%0d", k), tick[0], (k % 5 == 0) ? 1 : 0);
            check($sformatf("tog_out0_k%0d", k), clk_out[0], ((k / 5) % 2 == 1) ? 1 : 0);
        end
        en[0] = 1'b0;

        // ch1 pulse, N=3: clk_out equals tick, high 1 of 3
        div[16 +: 16] = 16'd3;
        mode[1]       = 1'b1;
        div[48 +: 16] = 16'd1;
        mode[3]       = 1'b0;
        step(1);
        check("dis_out0", clk_out[0], 0);
        en[1] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step(1);
            check($sformatf("pul_tick1_k%0d", k), tick[1], (k % 3 == 0) ? 1 : 0);
            check($sformatf("pul_out1_k%0d", k), clk_out[1], (k % 3 == 0) ? 1 : 0);
        end

        // div=0 acts as N=1; ch3 toggle with N=1 toggles every cycle
        en[1]         = 1'b0;
        div[16 +: 16] = 16'd0;
        step(1);
        check("dis_out1", clk_out[1], 0);
        check("dis_tick1", tick[1], 0);
        en[1] = 1'b1;
        en[3] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            if (k == 4) div[16 +: 16] = 16'd1;
            step(1);
            check($sformatf("n1_tick1_k%0d", k), tick[1], 1);
            check($sformatf("n1_out1_k%0d", k), clk_out[1], 1);
            check($sformatf("n1_out3_k%0d", k), clk_out[3], k % 2);
        end

        // shadowing: N=8, change to 2 at cnt=3 -> ticks at 8, 10, 12
        div[0 +: 16] = 16'd8;
        step(1);
        en[0] = 1'b1;
        step(3);
        div[0 +: 16] = 16'd2;
        for (int k = 4; k <= 12; k++) begin
            step(1);
            check($sformatf("shd_tick0_k%0d", k), tick[0], (k == 8 || k == 10 || k == 12) ? 1 : 0);
            check($sformatf("shd_out0_k%0d", k), clk_out[0], (k == 8 || k == 9 || k == 12) ? 1 : 0);
        end

        // sync alignment: ch0 N=4, ch2 N=6 started later
        div[0 +: 16]  = 16'd4;
        div[32 +: 16] = 16'd6;
        en[2]         = 1'b1;
        step(3);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        check("sync_tick", tick, 0);
        check("sync_out", clk_out, 0);
        for (int k = 1; k <= 12; k++) begin
            step(1);
            check($sformatf("sync_tick0_k%0d", k), tick[0], (k % 4 == 0) ? 1 : 0);
            check($sformatf("sync_tick2_k%0d", k), tick[2], (k % 6 == 0) ? 1 : 0);
        end
        step(8);
        check("pre_drop_out2", clk_out[2], 1);
        en[2] = 1'b0;
        step(1);
        check("drop_out2", clk_out[2], 0);
        check("drop_tick2", tick[2], 0);
        check("drop_keeps_out1", clk_out[1], 1);

        // asynchronous reset mid-period
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_out", clk_out, 0);
        check("async_rst_tick", tick, 0);
        en = '0;
        @(negedge clk);
        reset = 1'b1;
        step(1);
        check("post_rst_tick", tick, 0);
        en[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step(1);
            check($sformatf("rst_tick0_k%0d", k), tick[0], (k == 4) ? 1 : 0);
        end

        // 2-bit counter with div=3 wraps at cnt=2
        s_en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step(1);
            check($sformatf("small_tick_k%0d", k), s_tick, (k % 3 == 0) ? 1 : 0);
            check($sformatf("small_out_k%0d", k), s_clk_out, (k % 3 == 0) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
